// File: rtl/gf_minor_matrix.sv
// Matrix of minors of an up-to-3x3 matrix over GF(2^M), sequenced through two pipelined GF multipliers.
// Optional macro GF_MINOR_DET_EN adds det_out, the determinant, valid with done.
module gf_minor_matrix #(
    parameter int         M       = 6,
    parameter logic [M:0] POLY    = 7'b1000011,
    parameter int         MUL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     size,
    input  logic [9*M-1:0] in_mat,
    output logic [9*M-1:0] out_mat,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef GF_MINOR_DET_EN
    ,
    output logic [M-1:0]   det_out
`endif
);

`ifdef GF_MINOR_DET_EN
    typedef enum logic [2:0] {IDLE, LOAD, CALC, DET, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIN} state_t;
`endif

    localparam logic [3:0] LAST_PH = 4'(MUL_LAT);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M:0]   aa;
        logic [M-1:0] p;
        aa = {1'b0, a};
        p  = '0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ aa[M-1:0];
            aa = aa << 1;
            if (aa[M]) aa = aa ^ POLY;
        end
        return p;
    endfunction

    function automatic logic [3:0] kidx(input logic [1:0] i, input logic [1:0] j);
        return 4'(i) * 4'd3 + 4'(j);
    endfunction

    state_t         state_reg;
    logic [9*M-1:0] mat_reg;
    logic [1:0]     size_reg;
    logic [M-1:0]   buf_reg [9];
    logic [1:0]     row_reg, col_reg;
    logic [3:0]     ph_reg;
    logic [M-1:0]   opa0_reg, opa1_reg, opb0_reg, opb1_reg;
    logic [M-1:0]   a_prod, b_prod, a_res, b_res;
    logic [M-1:0]   mat_el [9];
    logic [9*M-1:0] buf_flat;
    logic [1:0]     r0, r1, c0, c1;
    logic [M-1:0]   iss_a0, iss_a1, iss_b0, iss_b1;
    logic           issue;
    logic [3:0]     k_idx;
`ifdef GF_MINOR_DET_EN
    logic [1:0]     dcnt_reg;
    logic [M-1:0]   det_reg;
`endif

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
            assign mat_el[gi]            = mat_reg[gi*M +: M];
            assign buf_flat[gi*M +: M]   = buf_reg[gi];
        end
    endgenerate

    // Rows/columns surviving removal of (row_reg, col_reg), kept in ascending order.
    always_comb begin
        r0     = (row_reg == 2'd0) ? 2'd1 : 2'd0;
        r1     = (row_reg == 2'd2) ? 2'd1 : 2'd2;
        c0     = (col_reg == 2'd0) ? 2'd1 : 2'd0;
        c1     = (col_reg == 2'd2) ? 2'd1 : 2'd2;
        k_idx  = kidx(row_reg, col_reg);
        iss_a0 = mat_el[kidx(r0, c0)];
        iss_a1 = mat_el[kidx(r1, c1)];
        iss_b0 = mat_el[kidx(r0, c1)];
        iss_b1 = mat_el[kidx(r1, c0)];
        issue  = (state_reg == CALC) && (ph_reg == 4'd0);
`ifdef GF_MINOR_DET_EN
        if (state_reg == DET) begin
            issue = (ph_reg == 4'd0);
            if (size_reg == 2'd2) begin
                iss_a0 = mat_el[0];
                iss_a1 = mat_el[4];
                iss_b0 = mat_el[1];
                iss_b1 = mat_el[3];
            end else begin
                // Cofactor expansion along row 0; multiplier B idles at zero.
                iss_a0 = mat_el[kidx(2'd0, dcnt_reg)];
                iss_a1 = buf_reg[dcnt_reg];
                iss_b0 = '0;
                iss_b1 = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa0_reg <= '0;
            opa1_reg <= '0;
            opb0_reg <= '0;
            opb1_reg <= '0;
        end else if (issue) begin
            opa0_reg <= iss_a0;
            opa1_reg <= iss_a1;
            opb0_reg <= iss_b0;
            opb1_reg <= iss_b1;
        end
    end

    assign a_prod = gf_mul(opa0_reg, opa1_reg);
    assign b_prod = gf_mul(opb0_reg, opb1_reg);

    // The result write itself is the last of the MUL_LAT stages, so only MUL_LAT-1 sit here.
    generate
        if (MUL_LAT == 1) begin : g_direct
            assign a_res = a_prod;
            assign b_res = b_prod;
        end else begin : g_pipe
            logic [M-1:0] a_pipe [MUL_LAT-1];
            logic [M-1:0] b_pipe [MUL_LAT-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT-1; i++) begin
                        a_pipe[i] <= '0;
                        b_pipe[i] <= '0;
                    end
                end else begin
                    a_pipe[0] <= a_prod;
                    b_pipe[0] <= b_prod;
                    for (int i = 1; i < MUL_LAT-1; i++) begin
                        a_pipe[i] <= a_pipe[i-1];
                        b_pipe[i] <= b_pipe[i-1];
                    end
                end
            end
            assign a_res = a_pipe[MUL_LAT-2];
            assign b_res = b_pipe[MUL_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mat_reg   <= '0;
            size_reg  <= '0;
            for (int i = 0; i < 9; i++) buf_reg[i] <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            ph_reg    <= '0;
            out_mat   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef GF_MINOR_DET_EN
            dcnt_reg  <= '0;
            det_reg   <= '0;
            det_out   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mat_reg  <= in_mat;
                        size_reg <= size;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        for (int i = 0; i < 9; i++) buf_reg[i] <= '0;
                        row_reg  <= '0;
                        col_reg  <= '0;
                        ph_reg   <= '0;
`ifdef GF_MINOR_DET_EN
                        dcnt_reg <= '0;
                        det_reg  <= '0;
`endif
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    case (size_reg)
                        2'd0: begin
                            err       <= 1'b1;
                            state_reg <= FIN;
                        end
                        2'd1: begin
                            buf_reg[0] <= M'(1);
`ifdef GF_MINOR_DET_EN
                            det_reg    <= mat_el[0];
`endif
                            state_reg  <= FIN;
                        end
                        2'd2: begin
                            buf_reg[0] <= mat_el[4];
                            buf_reg[1] <= mat_el[3];
                            buf_reg[3] <= mat_el[1];
                            buf_reg[4] <= mat_el[0];
`ifdef GF_MINOR_DET_EN
                            state_reg  <= DET;
`else
                            state_reg  <= FIN;
`endif
                        end
                        default: state_reg <= CALC;
                    endcase
                end
                CALC: begin
                    if (ph_reg == LAST_PH) begin
                        buf_reg[k_idx] <= a_res ^ b_res;
                        ph_reg <= '0;
                        if (col_reg == 2'd2) begin
                            col_reg <= '0;
                            if (row_reg == 2'd2) begin
                                row_reg <= '0;
`ifdef GF_MINOR_DET_EN
                                state_reg <= DET;
`else
                                state_reg <= FIN;
`endif
                            end else begin
                                row_reg <= row_reg + 2'd1;
                            end
                        end else begin
                            col_reg <= col_reg + 2'd1;
                        end
                    end else begin
                        ph_reg <= ph_reg + 4'd1;
                    end
                end
`ifdef GF_MINOR_DET_EN
                DET: begin
                    if (ph_reg == LAST_PH) begin
                        det_reg <= det_reg ^ a_res ^ b_res;
                        ph_reg  <= '0;
                        if (size_reg == 2'd2 || dcnt_reg == 2'd2) begin
                            state_reg <= FIN;
                        end else begin
                            dcnt_reg <= dcnt_reg + 2'd1;
                        end
                    end else begin
                        ph_reg <= ph_reg + 4'd1;
                    end
                end
`endif
                FIN: begin
                    if (!err) begin
                        out_mat <= buf_flat;
`ifdef GF_MINOR_DET_EN
                        det_out <= det_reg;
`endif
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_minor_matrix.sv
// Directed-vector bench for gf_minor_matrix (M=6, x^6+x+1, MUL_LAT=1); expected values hand-computed.
`timescale 1ns/1ps
module tb_gf_minor_matrix;
    localparam int M = 6;
`ifdef GF_MINOR_DET_EN
    localparam int LAT2 = 4;
    localparam int LAT3 = 26;
`else
    localparam int LAT2 = 2;
    localparam int LAT3 = 20;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     size = 2'd0;
    logic [9*M-1:0] in_mat = '0;
    logic [9*M-1:0] out_mat;
    logic           busy, done, err;
`ifdef GF_MINOR_DET_EN
    logic [M-1:0]   det_out;
`endif
    int total = 0;
    int bad = 0;

    gf_minor_matrix #(.M(M), .POLY(7'b1000011), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .in_mat(in_mat),
        .out_mat(out_mat), .busy(busy), .done(done), .err(err)
`ifdef GF_MINOR_DET_EN
        , .det_out(det_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9*M-1:0] mk9(input logic [M-1:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] n, input logic [9*M-1:0] m);
        size   = n;
        in_mat = m;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic busy1);
        lat   = -1;
        busy1 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) busy1 = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic transact(input string tag, input logic [1:0] n, input logic [9*M-1:0] m,
                            input int exp_lat, input logic [9*M-1:0] exp_out, input logic exp_err);
        int   lat;
        logic b1;
        issue(n, m);
        wait_done(lat, b1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(b1), 64'(1));
        chk({tag, "_out"}, 64'(out_mat), 64'(exp_out));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        $display("txn %s n=%0d lat=%0d err=%0b out=%h", tag, n, lat, err, out_mat);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int ndone;
        int first;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'(out_mat), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
`ifdef GF_MINOR_DET_EN
        chk("rst_det", 64'(det_out), 64'(0));
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        transact("n2", 2'd2, mk9(5, 7, 0, 9, 11, 0, 0, 0, 0), LAT2, mk9(11, 9, 0, 7, 5, 0, 0, 0, 0), 1'b0);
`ifdef GF_MINOR_DET_EN
        chk("n2_det", 64'(det_out), 64'(24));
`endif
        transact("diag248", 2'd3, mk9(2, 0, 0, 0, 4, 0, 0, 0, 8), LAT3, mk9(32, 0, 0, 0, 16, 0, 0, 0, 8), 1'b0);
`ifdef GF_MINOR_DET_EN
        chk("diag248_det", 64'(det_out), 64'(3));
`endif
        transact("diag3222", 2'd3, mk9(32, 0, 0, 0, 2, 0, 0, 0, 2), LAT3, mk9(4, 0, 0, 0, 3, 0, 0, 0, 3), 1'b0);
`ifdef GF_MINOR_DET_EN
        chk("diag3222_det", 64'(det_out), 64'(6));
`endif
        transact("n0", 2'd0, mk9(1, 2, 3, 4, 5, 6, 7, 8, 9), 2, mk9(4, 0, 0, 0, 3, 0, 0, 0, 3), 1'b1);
`ifdef GF_MINOR_DET_EN
        chk("n0_det", 64'(det_out), 64'(6));
`endif
        transact("n1", 2'd1, mk9(5, 1, 1, 1, 1, 1, 1, 1, 1), 2, mk9(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
`ifdef GF_MINOR_DET_EN
        chk("n1_det", 64'(det_out), 64'(5));
`endif

        // Snapshot: inputs change and start re-pulses while busy.
        issue(2'd3, mk9(2, 0, 0, 0, 4, 0, 0, 0, 8));
        ndone = 0;
        first = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) in_mat = mk9(63, 17, 5, 9, 1, 33, 12, 6, 40);
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        chk("snap_lat", 64'(first), 64'(LAT3));
        chk("snap_ndone", 64'(ndone), 64'(1));
        chk("snap_out", 64'(out_mat), 64'(mk9(32, 0, 0, 0, 16, 0, 0, 0, 8)));
`ifdef GF_MINOR_DET_EN
        chk("snap_det", 64'(det_out), 64'(3));
`endif
        $display("txn snapshot n=3 lat=%0d dones=%0d out=%h", first, ndone, out_mat);

        // Reset in the middle of an N=3 run.
        issue(2'd3, mk9(32, 0, 0, 0, 2, 0, 0, 0, 2));
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", 64'(out_mat), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_err", 64'(err), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", 64'(ndone), 64'(0));
        $display("txn abort n=3 dones_after=%0d out=%h", ndone, out_mat);

        transact("post_rst", 2'd2, mk9(5, 7, 0, 9, 11, 0, 0, 0, 0), LAT2, mk9(11, 9, 0, 7, 5, 0, 0, 0, 0), 1'b0);
`ifdef GF_MINOR_DET_EN
        chk("post_rst_det", 64'(det_out), 64'(24));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
